// File: rtl/seg16_pkg.sv
// Shared definitions for the 16-segment display path: segment width,
// blank code, scan state encoding and a small constant helper.
package seg16_pkg;

  localparam int SEG_W = 16;
  localparam logic [SEG_W-1:0] BLANK_CODE = 16'h0000;

  typedef enum logic {
    S_BLANK,
    S_ON
  } scan_state_e;

  // Larger of two integers; used to size the shared scan counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg16_frame_buffer.sv
// Double-buffered segment store: writes land in the shadow buffer, and a
// bulk copy moves the whole shadow into the active buffer that is scanned.
module seg16_frame_buffer
  import seg16_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  localparam int IDX_W = $clog2(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [2:0]       wr_idx_i,
  input  logic [SEG_W-1:0] wr_seg_i,
  input  logic             wr_found_i,
  input  logic             copy_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [SEG_W-1:0] rd_seg_o,
  output logic             idx_bad_o
);

  logic [SEG_W-1:0] shadow_q [NUM_DIGITS];
  logic [SEG_W-1:0] active_q [NUM_DIGITS];
  logic [SEG_W-1:0] wr_data;

  // Out-of-range positions are flagged; they never match a shadow slot below.
  assign idx_bad_o = ({1'b0, wr_idx_i} >= 4'(NUM_DIGITS));
  // A character the decoder did not recognise is shown blank.
  assign wr_data   = wr_found_i ? wr_seg_i : BLANK_CODE;

  // Shadow buffer: one slot updated per accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) shadow_q[i] <= BLANK_CODE;
    end else if (wr_en_i) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_idx_i == 3'(i)) shadow_q[i] <= wr_data;
      end
    end
  end

  // Active buffer: whole-frame copy so the display never shows a partial update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) active_q[i] <= BLANK_CODE;
    end else if (copy_i) begin
      for (int i = 0; i < NUM_DIGITS; i++) active_q[i] <= shadow_q[i];
    end
  end

  // Read mux selecting the active code for the digit being scanned.
  always_comb begin
    rd_seg_o = BLANK_CODE;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (rd_idx_i == IDX_W'(i)) rd_seg_o = active_q[i];
    end
  end

endmodule

// File: rtl/seg16_scan_driver.sv
// Time-multiplexed 16-segment display driver: scans one digit at a time with
// a blanking guard before each digit, and applies committed content only at
// frame boundaries.
module seg16_scan_driver
  import seg16_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int DIV        = 1000,
  parameter int BLANK_CYC  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [2:0]            wr_idx,
  input  logic [SEG_W-1:0]      wr_seg,
  input  logic                  wr_found,
  output logic                  wr_err,
  input  logic                  commit,
  output logic                  commit_pending,
  output logic [SEG_W-1:0]      seg_out,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  frame_start
);

  localparam int DW    = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(max_int(DIV, BLANK_CYC) + 1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [DW-1:0]    D_LAST     = DW'(NUM_DIGITS - 1);

  scan_state_e           state_q, state_d;
  logic [DW-1:0]         d_q, d_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  started_q, started_d;
  logic                  pending_q, pending_d;
  logic [SEG_W-1:0]      seg_out_q, seg_out_d;
  logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
  logic                  frame_start_q, frame_start_d;
  logic                  wr_err_q, wr_err_d;

  logic                  wr_fire;
  logic                  idx_bad;
  logic                  boundary;
  logic                  copy_en;
  logic [SEG_W-1:0]      rd_seg;

  assign wr_ready       = !pending_q && !commit;
  assign wr_fire        = wr_valid && wr_ready;
  assign commit_pending = pending_q;
  assign seg_out        = seg_out_q;
  assign dig_en         = dig_en_q;
  assign frame_start    = frame_start_q;
  assign wr_err         = wr_err_q;

  // Last lit cycle of the last digit: the only point where new content may land.
  assign boundary = started_q && (state_q == S_ON) && (d_q == D_LAST) && (cnt_q == DIV_LAST);
  assign copy_en  = boundary && (pending_q || commit);

  seg16_frame_buffer #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_fbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_fire),
    .wr_idx_i  (wr_idx),
    .wr_seg_i  (wr_seg),
    .wr_found_i(wr_found),
    .copy_i    (copy_en),
    .rd_idx_i  (d_q),
    .rd_seg_o  (rd_seg),
    .idx_bad_o (idx_bad)
  );

  // Next-state logic for the scan FSM, commit tracking and the output registers.
  // The first cycle after reset release is spent arming the scan so that the
  // first frame's opening BLANK cycle carries a frame_start pulse like every other frame.
  always_comb begin
    state_d   = state_q;
    d_d       = d_q;
    cnt_d     = cnt_q;
    started_d = 1'b1;
    if (started_q) begin
      if (state_q == S_BLANK) begin
        if (cnt_q == BLANK_LAST) begin
          state_d = S_ON;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        if (cnt_q == DIV_LAST) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          d_d     = (d_q == D_LAST) ? '0 : d_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // A commit landing exactly on the boundary is consumed by that copy.
    pending_d     = boundary ? 1'b0 : (commit ? 1'b1 : pending_q);
    frame_start_d = !started_q || boundary;
    // Entering or staying in ON keeps the same digit index, so d_q addresses it.
    seg_out_d     = (state_d == S_ON) ? rd_seg : BLANK_CODE;
    dig_en_d      = (state_d == S_ON) ? (NUM_DIGITS'(1) << d_q) : '0;
    wr_err_d      = wr_fire && idx_bad;
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_BLANK;
      d_q           <= '0;
      cnt_q         <= '0;
      started_q     <= 1'b0;
      pending_q     <= 1'b0;
      seg_out_q     <= BLANK_CODE;
      dig_en_q      <= '0;
      frame_start_q <= 1'b0;
      wr_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      d_q           <= d_d;
      cnt_q         <= cnt_d;
      started_q     <= started_d;
      pending_q     <= pending_d;
      seg_out_q     <= seg_out_d;
      dig_en_q      <= dig_en_d;
      frame_start_q <= frame_start_d;
      wr_err_q      <= wr_err_d;
    end
  end

endmodule

// File: tb/tb_seg16_scan_driver.sv
// Bench for seg16_scan_driver with a 6-digit, DIV=4, BLANK_CYC=1 (30-cycle) frame.
module tb_seg16_scan_driver;

  localparam int ND = 6;
  localparam int DV = 4;
  localparam int BC = 1;
  localparam int SLOT = BC + DV;
  localparam int FL = ND * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [2:0]  wr_idx = 3'd0;
  logic [15:0] wr_seg = 16'h0000;
  logic        wr_found = 1'b0;
  logic        wr_err;
  logic        commit = 1'b0;
  logic        commit_pending;
  logic [15:0] seg_out;
  logic [ND-1:0] dig_en;
  logic        frame_start;

  int errors = 0;
  int checks = 0;

  // Reference model: what the viewer should see, by position within the frame
  logic [15:0] shadow_m [ND];
  logic [15:0] active_m [ND];
  logic        pend_m;
  logic        err_m;
  int          pos;

  seg16_scan_driver #(
    .NUM_DIGITS(ND),
    .DIV       (DV),
    .BLANK_CYC (BC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_idx        (wr_idx),
    .wr_seg        (wr_seg),
    .wr_found      (wr_found),
    .wr_err        (wr_err),
    .commit        (commit),
    .commit_pending(commit_pending),
    .seg_out       (seg_out),
    .dig_en        (dig_en),
    .frame_start   (frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ND; i++) begin
      shadow_m[i] = 16'h0000;
      active_m[i] = 16'h0000;
    end
    pend_m = 1'b0;
    err_m  = 1'b0;
    pos    = 0;
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  // Entered and left 1 time unit after a rising edge.
  task automatic cycle(input logic wv, input logic [2:0] idx, input logic [15:0] sg,
                       input logic fd, input logic cm, output logic acc);
    logic        lit;
    int          dg;
    logic [15:0] es;
    logic [ND-1:0] ed;
    logic        bnd;
    wr_valid = wv;
    wr_idx   = idx;
    wr_seg   = sg;
    wr_found = fd;
    commit   = cm;
    @(negedge clk);
    dg  = pos / SLOT;
    lit = (pos % SLOT) >= BC;
    es  = lit ? active_m[dg] : 16'h0000;
    ed  = lit ? (6'b000001 << dg) : 6'b000000;
    chk("wr_ready", 32'(wr_ready), 32'(!pend_m && !cm));
    chk("seg_out", 32'(seg_out), 32'(es));
    chk("dig_en", 32'(dig_en), 32'(ed));
    chk("frame_start", 32'(frame_start), 32'(pos == 0));
    chk("commit_pending", 32'(commit_pending), 32'(pend_m));
    chk("wr_err", 32'(wr_err), 32'(err_m));
    acc = wv && !pend_m && !cm;
    bnd = (pos == FL - 1);
    if (bnd && (pend_m || cm)) begin
      for (int i = 0; i < ND; i++) active_m[i] = shadow_m[i];
    end
    pend_m = bnd ? 1'b0 : (cm ? 1'b1 : pend_m);
    if (acc && (int'(idx) < ND)) shadow_m[idx] = fd ? sg : 16'h0000;
    err_m = acc && (int'(idx) >= ND);
    pos   = (pos + 1) % FL;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic a;
    repeat (n) cycle(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, a);
  endtask

  task automatic run_to(input int p);
    logic a;
    for (int k = 0; k < FL && pos != p; k++) cycle(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, a);
  endtask

  // Wait (bounded) for the first frame_start after reset release.
  task automatic resync();
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (frame_start) break;
    end
    chk("sync_frame_start", 32'(frame_start), 32'd1);
    model_reset();
  endtask

  initial begin
    logic a;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_seg_out", 32'(seg_out), 32'd0);
    chk("rst_dig_en", 32'(dig_en), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_wr_err", 32'(wr_err), 32'd0);
    chk("rst_commit_pending", 32'(commit_pending), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    resync();

    // Two blank frames
    idle(2 * FL);

    // 'A' at position 0
    cycle(1'b1, 3'd0, 16'hF3C0, 1'b1, 1'b0, a);
    cycle(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, a);
    idle(FL);
    run_to(BC);
    chk("A_dig_en", 32'(dig_en), 32'h01);
    chk("A_seg_out", 32'(seg_out), 32'hF3C0);
    idle(FL);

    // Not-found character at position 2 is stored blank
    cycle(1'b1, 3'd2, 16'hFFFF, 1'b0, 1'b0, a);
    cycle(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, a);
    idle(FL);
    run_to(2 * SLOT + BC);
    chk("nf_dig_en", 32'(dig_en), 32'h04);
    chk("nf_seg_out", 32'(seg_out), 32'h0000);
    idle(FL);

    // Commit at cycle 10, with a write held through the pending window
    run_to(10);
    cycle(1'b1, 3'd1, 16'h1234, 1'b1, 1'b1, a);
    for (int k = 0; k < 2 * FL; k++) begin
      cycle(1'b1, 3'd1, 16'h1234, 1'b1, 1'b0, a);
      if (a) break;
    end
    cycle(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, a);
    idle(2 * FL);

    // Out-of-range index
    cycle(1'b1, 3'd7, 16'hABCD, 1'b1, 1'b0, a);
    chk("wr_err_pulse", 32'(wr_err), 32'd1);
    idle(2);
    cycle(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, a);
    idle(2 * FL);

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0), a);
    end
    idle(2 * FL);

    // Async reset mid-ON on digit 3 with a commit pending
    cycle(1'b1, 3'd3, 16'h5A5A, 1'b1, 1'b0, a);
    cycle(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, a);
    idle(FL);
    run_to(12);
    cycle(1'b1, 3'd3, 16'h0F0F, 1'b1, 1'b0, a);
    cycle(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, a);
    run_to(3 * SLOT + 2);
    chk("pre_rst_dig_en", 32'(dig_en), 32'h08);
    chk("pre_rst_seg_out", 32'(seg_out), 32'h5A5A);
    chk("pre_rst_pending", 32'(commit_pending), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_seg_out", 32'(seg_out), 32'd0);
    chk("async_dig_en", 32'(dig_en), 32'd0);
    chk("async_pending", 32'(commit_pending), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    resync();
    idle(FL);
    cycle(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, a);
    idle(2 * FL);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
